// File: rtl/quad_encoder_emulator.sv
// quad_encoder_emulator: command-driven quadrature (A/B) source with a wrapping
// position counter. Commands give a direction, an edge count and an edge spacing
// and are taken over a valid/ready handshake while the block is idle.
// Optional feature macro: QUAD_INDEX_EN adds a revolution counter (0..CPR-1) and
// drives index high whenever that counter sits at 0; without it index is tied low.
module quad_encoder_emulator #(
  parameter int COUNT_W = 16,
  parameter int DIV_W   = 16,
  parameter int POS_W   = 16,
  parameter int CPR     = 400
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic [DIV_W-1:0]   cmd_period,
  input  logic               abort,
  output logic               enc_A,
  output logic               enc_B,
  output logic               busy,
  output logic               done,
  output logic [POS_W-1:0]   position,
  output logic               index
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0]   DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0]   DIV_ZERO  = {DIV_W{1'b0}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] COUNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [POS_W-1:0]   POS_ONE   = {{(POS_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [DIV_W-1:0]   period_q, period_d;
  logic [DIV_W-1:0]   timer_q, timer_d;
  logic [1:0]         ab_q, ab_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               edge_s;
  logic [DIV_W-1:0]   period_eff_s;

  // One Gray-code step of {A,B}: forward 00->10->11->01->00, reverse is the inverse.
  function automatic logic [1:0] step_ab(input logic [1:0] ab, input logic fwd);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = fwd ? 2'b10 : 2'b01;
      2'b10:   nxt = fwd ? 2'b11 : 2'b00;
      2'b11:   nxt = fwd ? 2'b01 : 2'b10;
      2'b01:   nxt = fwd ? 2'b00 : 2'b11;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // A zero spacing would never expire, so it is promoted to one clock.
  always_comb begin
    if (cmd_period == DIV_ZERO) begin
      period_eff_s = DIV_ONE;
    end else begin
      period_eff_s = cmd_period;
    end
  end

  // Command sequencing: accept in IDLE, pace edges in RUN, one-cycle FIN before IDLE.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    remaining_d = remaining_q;
    period_d    = period_q;
    timer_d     = timer_q;
    edge_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          dir_d       = cmd_dir;
          remaining_d = cmd_count;
          period_d    = period_eff_s;
          timer_d     = period_eff_s;
          if (cmd_count != COUNT_ZERO) begin
            state_d = S_RUN;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          // Abort wins over a due edge so no partial step is ever emitted.
          state_d = S_FIN;
        end else if (timer_q == DIV_ONE) begin
          edge_s      = 1'b1;
          timer_d     = period_q;
          remaining_d = remaining_q - COUNT_ONE;
          if (remaining_q == COUNT_ONE) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          timer_d = timer_q - DIV_ONE;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Phase and position advance only on an emitted edge; they persist across commands.
  always_comb begin
    if (edge_s) begin
      ab_d = step_ab(ab_q, dir_q);
      if (dir_q) begin
        pos_d = pos_q + POS_ONE;
      end else begin
        pos_d = pos_q - POS_ONE;
      end
    end else begin
      ab_d  = ab_q;
      pos_d = pos_q;
    end
  end

  // Status flags: done trails the FIN state by one clock, ready/busy follow the next state.
  always_comb begin
    busy_d  = (state_d == S_RUN);
    ready_d = (state_d == S_IDLE);
    done_d  = (state_q == S_FIN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      remaining_q <= COUNT_ZERO;
      period_q    <= DIV_ONE;
      timer_q     <= DIV_ONE;
      ab_q        <= 2'b00;
      pos_q       <= {POS_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      remaining_q <= remaining_d;
      period_q    <= period_d;
      timer_q     <= timer_d;
      ab_q        <= ab_d;
      pos_q       <= pos_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign enc_A     = ab_q[1];
  assign enc_B     = ab_q[0];
  assign position  = pos_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

`ifdef QUAD_INDEX_EN
  localparam int REV_W = (CPR > 1) ? $clog2(CPR) : 1;
  localparam logic [REV_W-1:0] REV_MAX  = REV_W'(CPR - 1);
  localparam logic [REV_W-1:0] REV_ONE  = {{(REV_W-1){1'b0}}, 1'b1};
  localparam logic [REV_W-1:0] REV_ZERO = {REV_W{1'b0}};

  logic [REV_W-1:0] rev_q, rev_d;
  logic             index_q, index_d;

  // Revolution counter steps with every edge and wraps at CPR in both directions.
  always_comb begin
    if (edge_s) begin
      if (dir_q) begin
        if (rev_q == REV_MAX) begin
          rev_d = REV_ZERO;
        end else begin
          rev_d = rev_q + REV_ONE;
        end
      end else begin
        if (rev_q == REV_ZERO) begin
          rev_d = REV_MAX;
        end else begin
          rev_d = rev_q - REV_ONE;
        end
      end
    end else begin
      rev_d = rev_q;
    end
    index_d = (rev_d == REV_ZERO);
  end

  // Index register updates on the same clock as A/B.
  always_ff @(posedge clk) begin
    if (reset) begin
      rev_q   <= REV_ZERO;
      index_q <= 1'b1;
    end else begin
      rev_q   <= rev_d;
      index_q <= index_d;
    end
  end

  assign index = index_q;
`else
  assign index = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Self-checking bench for quad_encoder_emulator. The reference model predicts, for
// every clock after a command is accepted, how many edges have been emitted using
// plain arithmetic on (period, count, abort time) and maps that onto the Gray table.
module tb_quad_encoder_emulator;

  localparam int CPR_T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_count;
  logic [15:0] cmd_period;
  logic        abort;
  logic        enc_A;
  logic        enc_B;
  logic        busy;
  logic        done;
  logic [15:0] position;
  logic        index;

  int vec  = 0;
  int errs = 0;

  // reference model state (what the outputs should show between commands)
  int          m_phase = 0;
  logic [15:0] m_pos   = 16'd0;
  int          m_rev   = 0;
  logic [1:0]  ab_tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quad_encoder_emulator #(
    .COUNT_W(16), .DIV_W(16), .POS_W(16), .CPR(CPR_T)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_period(cmd_period), .abort(abort),
    .enc_A(enc_A), .enc_B(enc_B), .busy(busy), .done(done),
    .position(position), .index(index)
  );

  always #5 clk = ~clk;

  // A and B must never change in the same clock (reset excepted)
  logic [1:0] last_ab;
  logic       rst_at_edge;
  logic       mon_started = 1'b0;
  always @(posedge clk) rst_at_edge <= reset;
  always @(negedge clk) begin
    if (mon_started && rst_at_edge === 1'b0) begin
      vec++;
      if ((enc_A !== last_ab[1]) && (enc_B !== last_ab[0])) begin
        errs++;
        $display("FAIL dual_toggle: AB %b -> %b%b, required single-bit change", last_ab, enc_A, enc_B);
      end
    end
    last_ab     = {enc_A, enc_B};
    mon_started = 1'b1;
  end

  function automatic int wrap(int v, int m);
    return ((v % m) + m) % m;
  endfunction

  // edges emitted by clock k after accept: one every per clocks, capped by count,
  // and none at or after an abort taken at clock a
  function automatic int n_edges(int k, int count, int per, int a);
    int lim = k;
    int n;
    if (a >= 1 && (a - 1) < lim) lim = a - 1;
    n = lim / per;
    if (n > count) n = count;
    return n;
  endfunction

  // Issue one command and check every clock until done has pulsed.
  // a: -1 no abort, 0 abort asserted with the accept (ignored), >=1 abort sampled at clock a
  task automatic run_cmd(input logic dir, input int count, input int period, input int a,
                         input logic keep, input string tag);
    int per   = (period == 0) ? 1 : period;
    int sgn   = dir ? 1 : -1;
    int t_end;
    int guard = 0;
    int n;
    logic [1:0]  exp_ab;
    logic [15:0] exp_pos;
    logic        exp_idx;
    t_end = (count == 0) ? 0 : ((a >= 1) ? a : count * per);
    while (cmd_ready !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    vec++;
    if (guard >= 64) begin
      errs++;
      $display("FAIL %s ready_wait: cmd_ready=%b required 1", tag, cmd_ready);
    end
    cmd_dir    = dir;
    cmd_count  = count[15:0];
    cmd_period = period[15:0];
    cmd_valid  = 1'b1;
    abort      = (a == 0);
    @(posedge clk);
    #1;
    abort      = 1'b0;
    cmd_valid  = keep;
    cmd_dir    = 1'($urandom);
    cmd_count  = 16'($urandom);
    cmd_period = 16'($urandom);
    for (int k = 0; k <= t_end + 1; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        abort = 1'b0;
      end
      @(negedge clk);
      n       = n_edges(k, count, per, a);
      exp_ab  = ab_tbl[wrap(m_phase + sgn * n, 4)];
      exp_pos = m_pos + 16'(sgn * n);
`ifdef QUAD_INDEX_EN
      exp_idx = (wrap(m_rev + sgn * n, CPR_T) == 0);
`else
      exp_idx = 1'b0;
`endif
      vec++;
      if ({enc_A, enc_B} !== exp_ab) begin
        errs++;
        $display("FAIL %s ab@%0d: got %b%b required %b", tag, k, enc_A, enc_B, exp_ab);
      end
      vec++;
      if (position !== exp_pos) begin
        errs++;
        $display("FAIL %s pos@%0d: got %h required %h", tag, k, position, exp_pos);
      end
      vec++;
      if (busy !== (count > 0 && k < t_end)) begin
        errs++;
        $display("FAIL %s busy@%0d: got %b required %b", tag, k, busy, (count > 0 && k < t_end));
      end
      vec++;
      if (done !== (k == t_end + 1)) begin
        errs++;
        $display("FAIL %s done@%0d: got %b required %b", tag, k, done, (k == t_end + 1));
      end
      vec++;
      if (cmd_ready !== (k == t_end + 1)) begin
        errs++;
        $display("FAIL %s ready@%0d: got %b required %b", tag, k, cmd_ready, (k == t_end + 1));
      end
      vec++;
      if (index !== exp_idx) begin
        errs++;
        $display("FAIL %s index@%0d: got %b required %b", tag, k, index, exp_idx);
      end
      if (k + 1 == a) abort = 1'b1;
    end
    n       = n_edges(t_end + 1, count, per, a);
    m_phase = wrap(m_phase + sgn * n, 4);
    m_pos   = m_pos + 16'(sgn * n);
    m_rev   = wrap(m_rev + sgn * n, CPR_T);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec++;
    if ({enc_A, enc_B, busy, done, cmd_ready} !== 5'b00000 || position !== 16'd0) begin
      errs++;
      $display("FAIL reset_vals: ab=%b%b busy=%b done=%b ready=%b pos=%h required all 0",
               enc_A, enc_B, busy, done, cmd_ready, position);
    end
    vec++;
`ifdef QUAD_INDEX_EN
    if (index !== 1'b1) begin
      errs++;
      $display("FAIL reset_index: got %b required 1", index);
    end
`else
    if (index !== 1'b0) begin
      errs++;
      $display("FAIL reset_index: got %b required 0", index);
    end
`endif
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: ready=%b busy=%b done=%b required 1,0,0", cmd_ready, busy, done);
    end
    m_phase = 0;
    m_pos   = 16'd0;
    m_rev   = 0;
  endtask

  task automatic test_forward();
    test_reset();
    run_cmd(1'b1, 4, 3, -1, 1'b0, "fwd4");
    vec++;
    if (position !== 16'd4 || {enc_A, enc_B} !== 2'b00) begin
      errs++;
      $display("FAIL fwd4_end: pos=%h ab=%b%b required 0004 00", position, enc_A, enc_B);
    end
  endtask

  task automatic test_reverse_wrap();
    test_reset();
    run_cmd(1'b0, 2, 1, -1, 1'b0, "rev2");
    vec++;
    if (position !== 16'hFFFE || {enc_A, enc_B} !== 2'b11) begin
      errs++;
      $display("FAIL rev2_end: pos=%h ab=%b%b required fffe 11", position, enc_A, enc_B);
    end
  endtask

  task automatic test_count_zero();
    run_cmd(1'b1, 0, 7, -1, 1'b0, "cnt0");
  endtask

  task automatic test_abort();
    test_reset();
    run_cmd(1'b1, 100, 5, 12, 1'b0, "abort");
    vec++;
    if ({enc_A, enc_B} !== 2'b11 || position !== 16'd2) begin
      errs++;
      $display("FAIL abort_end: ab=%b%b pos=%h required 11 0002", enc_A, enc_B, position);
    end
    run_cmd(1'b0, 3, 2, 6, 1'b0, "abort_on_edge");
    run_cmd(1'b1, 2, 2, 0, 1'b0, "abort_idle");
  endtask

  task automatic test_period_zero();
    run_cmd(1'b1, 3, 0, -1, 1'b0, "per0");
  endtask

  task automatic test_back_to_back();
    run_cmd(1'b1, 3, 2, -1, 1'b1, "b2b_a");
    run_cmd(1'b0, 2, 3, -1, 1'b1, "b2b_b");
    run_cmd(1'b1, 0, 1, -1, 1'b1, "b2b_c");
    run_cmd(1'b1, 5, 1, -1, 1'b0, "b2b_d");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic d;
      int   c, p, pe, r, a;
      logic kp;
      d  = 1'($urandom_range(0, 1));
      c  = $urandom_range(0, 6);
      p  = $urandom_range(0, 4);
      pe = (p == 0) ? 1 : p;
      r  = $urandom_range(0, 3);
      a  = -1;
      if (r == 0 && c > 0) a = $urandom_range(1, c * pe);
      if (r == 1) a = 0;
      kp = (i == 29) ? 1'b0 : 1'($urandom_range(0, 1));
      run_cmd(d, c, p, a, kp, "rand");
    end
  endtask

  task automatic test_reset_mid_run();
    int guard = 0;
    while (cmd_ready !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    cmd_dir    = 1'b1;
    cmd_count  = 16'd10;
    cmd_period = 16'd2;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    vec++;
    if ({enc_A, enc_B, busy, done, cmd_ready} !== 5'b00000 || position !== 16'd0) begin
      errs++;
      $display("FAIL midrst_vals: ab=%b%b busy=%b done=%b ready=%b pos=%h required all 0",
               enc_A, enc_B, busy, done, cmd_ready, position);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
        errs++;
        $display("FAIL midrst_after@%0d: done=%b ready=%b required 0 1", k, done, cmd_ready);
      end
    end
    m_phase = 0;
    m_pos   = 16'd0;
    m_rev   = 0;
    run_cmd(1'b1, 2, 1, -1, 1'b0, "post_rst");
  endtask

`ifdef QUAD_INDEX_EN
  task automatic test_index();
    test_reset();
    run_cmd(1'b1, 8, 1, -1, 1'b0, "idx_fwd8");
    vec++;
    if (index !== 1'b1) begin
      errs++;
      $display("FAIL idx_fwd8_end: got %b required 1", index);
    end
    run_cmd(1'b0, 1, 1, -1, 1'b0, "idx_rev1");
    vec++;
    if (index !== 1'b0) begin
      errs++;
      $display("FAIL idx_rev1_end: got %b required 0", index);
    end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_count  = 16'd0;
    cmd_period = 16'd0;
    abort      = 1'b0;
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_count_zero();
    test_abort();
    test_period_zero();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
`ifdef QUAD_INDEX_EN
    test_index();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
